// File: rtl/psum_accumulator.sv
// psum_accumulator: running sum of adder results per packet,
// with beat count and sticky carry presented on a valid/ready output.
module psum_accumulator #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_out_ovf;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_first;
  logic              w_close;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W:0]   w_sum_ext;
  logic [DATA_W-1:0] w_sum;
  logic              w_carry;
  logic              w_ovf_nxt;

  // Ready only while accumulating, and never while reset is held.
  assign w_in_ready = (r_state == ST_ACC) & ~rst;
  assign w_accept   = in_valid & w_in_ready;

  // The first beat of a packet loads rather than adds, so a stale
  // sum left over from the previous packet never leaks in.
  assign w_first   = (r_cnt == '0);
  assign w_cnt_inc = r_cnt + LP_ONE;
  assign w_sum_ext = w_first
                   ? {1'b0, in_data}
                   : {1'b0, r_acc} + {1'b0, in_data};
  assign w_sum     = w_sum_ext[DATA_W-1:0];
  assign w_carry   = w_sum_ext[DATA_W];
  assign w_ovf_nxt = w_first ? 1'b0 : (r_ovf | w_carry);

  // A packet closes on in_last or when it reaches the length cap.
  assign w_close = w_accept
                 & (in_last | (w_cnt_inc == LP_MAX));

  // Next-state and handshake outputs of the ACC/HOLD controller.
  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    unique case (r_state)
      ST_ACC: begin
        if (w_close) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_ACC;
        end
      end
      default: begin
        w_state_nxt = ST_ACC;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running sum, beat count and sticky carry for the open packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_close ? '0 : w_cnt_inc;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Result registers: captured on close, held until the next close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_close) begin
      r_out_data  <= w_sum;
      r_out_count <= w_cnt_inc;
      r_out_ovf   <= w_ovf_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule
